// File: rtl/piezo_arbiter.sv
// piezo_arbiter: shares one piezo bender among NUM_REQ tune players, one tune at a time.
// Define PIEZO_RR_EN for round-robin arbitration; default build is fixed priority (lowest index).
module piezo_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned FAST_SIM   = 1,
  parameter logic [26:0] GAP_CYCLES = 27'd2500000,
  parameter logic [26:0] TIMEOUT    = 27'd100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  input  logic [NUM_REQ-1:0] piezo_in,
  output logic [NUM_REQ-1:0] go,
  output logic               piezo,
  output logic               piezo_n,
  output logic               busy,
  output logic [2:0]         grant_id,
  output logic               timeout_err
);

  typedef enum logic [1:0] {StIdle, StStart, StPlay, StGap} state_e;

  localparam logic [26:0] Step   = (FAST_SIM != 0) ? 27'd16 : 27'd1;
  localparam logic [26:0] CntMax = '1;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] req_q, pend_q, pend_d, req_rise, pend_clr;
  logic [26:0]        cnt_q, cnt_d, cnt_inc;
  logic [2:0]         grant_q, grant_d, winner;
  logic               sel_in, sel_done;

  assign req_rise = req & ~req_q;
  assign pend_d   = (pend_q & ~pend_clr) | req_rise;
  assign cnt_inc  = (cnt_q > CntMax - Step) ? CntMax : cnt_q + Step;
  assign busy     = (state_q != StIdle);
  assign grant_id = grant_q;

  // Drive and done of the player named by the registered grant
  always_comb begin
    sel_in   = 1'b0;
    sel_done = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        sel_in   = piezo_in[i];
        sel_done = done[i];
      end
    end
  end

`ifdef PIEZO_RR_EN
  // Smallest distance after the last grant wins
  always_comb begin
    int unsigned best;
    int unsigned dist;
    winner = '0;
    best   = NUM_REQ;
    dist   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      dist = (i + NUM_REQ - 32'(grant_q) - 1) % NUM_REQ;
      if (pend_q[i] && (dist < best)) begin
        best   = dist;
        winner = 3'(i);
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (pend_q[i]) winner = 3'(i);
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    pend_clr    = '0;
    go          = '0;
    piezo       = 1'b0;
    piezo_n     = 1'b0;
    timeout_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pend_q != '0) begin
          grant_d = winner;
          state_d = StStart;
        end
      end
      StStart: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) go[i] = (grant_q == 3'(i));
        pend_clr = go;
        cnt_d    = '0;
        state_d  = StPlay;
      end
      StPlay: begin
        piezo   = sel_in;
        piezo_n = ~sel_in;
        if (sel_done) begin
          state_d = StGap;
          cnt_d   = '0;
        end else if (cnt_q >= TIMEOUT) begin
          state_d     = StGap;
          cnt_d       = '0;
          timeout_err = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StGap: begin
        if (cnt_q >= GAP_CYCLES) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    // Sampled during reset as well, so a request held high across reset is not seen as an edge
    req_q <= req;
    if (rst) begin
      state_q <= StIdle;
      pend_q  <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_piezo_arbiter.sv
// tb_piezo_arbiter: randomized stimulus, phase-level reference model and per-cycle scoreboard.
module tb_piezo_arbiter;

  localparam int unsigned N         = 3;
  localparam int unsigned GapCycles = 100;
  localparam int unsigned Timeout   = 480;
  localparam int unsigned Step      = 16;
  // Cycles spent in a phase before the limit is reached, counting from 0 on entry
  localparam int unsigned PlayLim   = (Timeout + Step - 1) / Step;
  localparam int unsigned GapLim    = (GapCycles + Step - 1) / Step;
  localparam int          NumCycles = 4000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] piezo_in = '0;
  logic [N-1:0] go;
  logic         piezo, piezo_n, busy, timeout_err;
  logic [2:0]   grant_id;

  piezo_arbiter #(
    .NUM_REQ   (N),
    .FAST_SIM  (1),
    .GAP_CYCLES(27'(GapCycles)),
    .TIMEOUT   (27'(Timeout))
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .piezo_in   (piezo_in),
    .go         (go),
    .piezo      (piezo),
    .piezo_n    (piezo_n),
    .busy       (busy),
    .grant_id   (grant_id),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] go;
    logic         pz;
    logic         pzn;
    logic         busy;
    logic         terr;
    logic [2:0]   gid;
  } exp_t;

  typedef struct {
    int cyc;
    int id;
  } grant_t;

  exp_t   exp_q[$];
  grant_t gnt_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     mon_en = 1'b0;

  // Reference model: which phase we are in and how long we have been there
  typedef enum int {MIdle, MStart, MPlay, MGap} phase_e;
  phase_e       ph;
  int           elapsed;
  int           grant;
  bit           pend[N];
  logic [N-1:0] req_prev;

  function automatic int pick();
    int start;
    start = 0;
`ifdef PIEZO_RR_EN
    start = (grant + 1) % N;
`endif
    for (int k = 0; k < N; k++) begin
      if (pend[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ph      = MIdle;
    elapsed = 0;
    grant   = 0;
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
  endtask

  task automatic model_cycle();
    exp_t         e;
    grant_t       g;
    logic [N-1:0] rise;
    int           w;
    e      = '0;
    e.busy = (ph != MIdle);
    e.gid  = 3'(grant);
    if (ph == MStart) begin
      e.go[grant] = 1'b1;
      g.cyc = cyc;
      g.id  = grant;
      gnt_q.push_back(g);
    end
    if (ph == MPlay) begin
      e.pz   = piezo_in[grant];
      e.pzn  = !piezo_in[grant];
      e.terr = (elapsed >= PlayLim) && !done[grant];
    end
    exp_q.push_back(e);

    rise     = req & ~req_prev;
    req_prev = req;
    if (rst) begin
      model_reset();
      return;
    end
    case (ph)
      MIdle: begin
        w = pick();
        if (w >= 0) begin
          grant = w;
          ph    = MStart;
        end
      end
      MStart: begin
        pend[grant] = 1'b0;
        ph          = MPlay;
        elapsed     = 0;
      end
      MPlay: begin
        if (done[grant] || elapsed >= PlayLim) begin
          ph      = MGap;
          elapsed = 0;
        end else begin
          elapsed++;
        end
      end
      default: begin
        if (elapsed >= GapLim) ph = MIdle;
        else elapsed++;
      end
    endcase
    for (int k = 0; k < N; k++) if (rise[k]) pend[k] = 1'b1;
  endtask

  task automatic toggle_req(input int unsigned odds);
    for (int k = 0; k < N; k++) if ($urandom_range(0, odds - 1) == 0) req[k] = ~req[k];
  endtask

  task automatic drive(input int c);
    logic [31:0] r;
    int unsigned j;
    r        = $urandom;
    piezo_in = r[N-1:0];
    rst      = 1'b0;
    done     = '0;
    case (c / 800)
      0: begin
        toggle_req(16);
        if (ph == MPlay && $urandom_range(0, 9) == 0) done[grant] = 1'b1;
        if ($urandom_range(0, 19) == 0) begin
          j       = $urandom_range(0, N - 1);
          done[j] = 1'b1;
        end
        if ($urandom_range(0, 399) == 0) rst = 1'b1;
      end
      1: begin
        // Granted player never finishes; other players' done toggles freely
        toggle_req(30);
        r    = $urandom;
        done = r[N-1:0];
        if (ph == MPlay) done[grant] = 1'b0;
      end
      2: begin
        toggle_req(30);
        if (ph == MPlay && elapsed == PlayLim) done[grant] = 1'b1;
      end
      3: begin
        req = ((c % 8) < 2) ? '1 : '0;
        if (ph == MPlay && $urandom_range(0, 3) == 0) done[grant] = 1'b1;
      end
      default: begin
        // Requests mostly held high while reset strikes often
        toggle_req(40);
        if ($urandom_range(0, 3) != 0) req = '1;
        if (ph == MPlay && $urandom_range(0, 4) == 0) done[grant] = 1'b1;
        if ($urandom_range(0, 39) == 0) rst = 1'b1;
      end
    endcase
  endtask

  always @(negedge clk) begin
    exp_t   e;
    exp_t   a;
    grant_t g;
    if (mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL outputs cyc=%0d actual: no expectation queued, required: one per cycle", cyc);
      end else begin
        e = exp_q.pop_front();
        a = {go, piezo, piezo_n, busy, timeout_err, grant_id};
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cyc=%0d actual go=%b piezo=%b piezo_n=%b busy=%b terr=%b gid=%0d required go=%b piezo=%b piezo_n=%b busy=%b terr=%b gid=%0d",
                   cyc, a.go, a.pz, a.pzn, a.busy, a.terr, a.gid,
                   e.go, e.pz, e.pzn, e.busy, e.terr, e.gid);
        end
      end
      if (go != '0) begin
        checks++;
        if (gnt_q.size() == 0) begin
          errors++;
          $display("FAIL grant_order cyc=%0d actual go=%b, required no go pulse", cyc, go);
        end else begin
          g = gnt_q.pop_front();
          if (g.cyc != cyc || int'(grant_id) != g.id) begin
            errors++;
            $display("FAIL grant_order actual cyc=%0d id=%0d required cyc=%0d id=%0d",
                     cyc, grant_id, g.cyc, g.id);
          end
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    model_reset();
    req_prev = '0;
    for (int c = 0; c < NumCycles; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      if (c < 3) begin
        rst      = (c == 0);
        req      = '0;
        done     = '0;
        piezo_in = '1;
      end else begin
        drive(c);
      end
      model_cycle();
      mon_en = 1'b1;
    end
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_outputs actual %0d left, required 0", exp_q.size());
    end
    checks++;
    if (gnt_q.size() != 0) begin
      errors++;
      $display("FAIL drain_grants actual %0d go pulses missing, required 0", gnt_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
